// File: rtl/source_packet_gen_pkg.sv
// Shared types and constants for the source packet generator: FSM states, scrambler
// seed/taps, header word field offsets and the LFSR next-state function.
package source_packet_gen_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHead,
    StLen,
    StFlag,
    StPayload,
    StDone
  } state_e;

  localparam logic [15:0] LfsrSeedDefault = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1 in a shift-left register: bits 15, 13, 12, 10
  localparam logic [15:0] LfsrTaps = 16'hB400;

  localparam int unsigned LenOff  = 0;
  localparam int unsigned FlagOff = 16;
  localparam int unsigned SeqOff  = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] state);
    return {state[14:0], ^(state & LfsrTaps)};
  endfunction

endpackage

// File: rtl/source_lfsr16.sv
// 16-bit Fibonacci scrambler LFSR with synchronous reload; exposes both the current
// state and the state it will take on the next step.
module source_lfsr16
  import source_packet_gen_pkg::*;
#(
  parameter logic [15:0] SEED = LfsrSeedDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_step,
  output logic [15:0] o_state,
  output logic [15:0] o_next
);

  logic [15:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED;
    end else if (i_load) begin
      r_state <= SEED;
    end else if (i_step) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign o_state = r_state;
  assign o_next  = lfsr_step(r_state);

endmodule

// File: rtl/source_packet_gen.sv
// Emits one framed packet (head, length, flag/seq, payload) per accepted start on a
// registered valid/ready stream with SOP/EOP markers.
module source_packet_gen
  import source_packet_gen_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = LfsrSeedDefault,
  parameter int unsigned LEN_W     = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [31:0]      i_packet_head,
  input  logic [15:0]      i_flag_set,
  input  logic [LEN_W-1:0] i_length_set,
  input  logic             i_scramble,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_dout,
  output logic             o_dout_valid,
  input  logic             i_dout_ready,
  output logic             o_dout_sop,
  output logic             o_dout_eop
);

  state_e           r_state, w_state_d;
  logic [LEN_W-1:0] r_len, r_cnt, w_cnt_d, w_cnt_inc;
  logic [15:0]      r_flag, r_seq, w_seq_d;
  logic             r_scr;
  logic [31:0]      r_dout, w_dout_d;
  logic             r_valid, w_valid_d, r_sop, w_sop_d, r_eop, w_eop_d;
  logic             r_busy, w_busy_d, r_done, w_done_d;
  logic             w_accept, w_snap, w_lfsr_load, w_lfsr_step;
  logic [15:0]      w_lfsr_state, w_lfsr_next;

  source_lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_lfsr_load),
    .i_step (w_lfsr_step),
    .o_state(w_lfsr_state),
    .o_next (w_lfsr_next)
  );

  assign w_accept  = r_valid & i_dout_ready;
  assign w_cnt_inc = r_cnt + LEN_W'(1);

  // Next-word values are computed here and registered, so each word is loaded on the
  // acceptance of its predecessor and held untouched while the sink stalls.
  always_comb begin
    w_state_d   = r_state;
    w_dout_d    = r_dout;
    w_valid_d   = r_valid;
    w_sop_d     = r_sop;
    w_eop_d     = r_eop;
    w_busy_d    = r_busy;
    w_done_d    = 1'b0;
    w_cnt_d     = r_cnt;
    w_seq_d     = r_seq;
    w_snap      = 1'b0;
    w_lfsr_load = 1'b0;
    w_lfsr_step = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d   = StHead;
          w_dout_d    = i_packet_head;
          w_valid_d   = 1'b1;
          w_sop_d     = 1'b1;
          w_eop_d     = 1'b0;
          w_busy_d    = 1'b1;
          w_snap      = 1'b1;
          w_lfsr_load = 1'b1;
        end
      end
      StHead: begin
        if (w_accept) begin
          w_state_d = StLen;
          w_dout_d  = 32'(r_len) << LenOff;
          w_sop_d   = 1'b0;
        end
      end
      StLen: begin
        if (w_accept) begin
          w_state_d = StFlag;
          w_dout_d  = (32'(r_flag) << FlagOff) | (32'(r_seq) << SeqOff);
          w_eop_d   = (r_len == '0);
        end
      end
      StFlag, StPayload: begin
        if (w_accept) begin
          w_lfsr_step = (r_state == StPayload);
          if (r_eop) begin
            w_state_d = StDone;
            w_dout_d  = '0;
            w_valid_d = 1'b0;
            w_eop_d   = 1'b0;
            w_busy_d  = 1'b0;
            w_done_d  = 1'b1;
          end else if (r_state == StFlag) begin
            w_state_d = StPayload;
            w_cnt_d   = '0;
            w_dout_d  = r_scr ? {w_lfsr_state, w_lfsr_state} : 32'h0;
            w_eop_d   = (r_len == LEN_W'(1));
          end else begin
            w_cnt_d  = w_cnt_inc;
            w_dout_d = 32'(w_cnt_inc) ^ (r_scr ? {w_lfsr_next, w_lfsr_next} : 32'h0);
            w_eop_d  = (w_cnt_inc == r_len - LEN_W'(1));
          end
        end
      end
      StDone: begin
        w_state_d = StIdle;
        w_seq_d   = r_seq + 16'd1;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_len   <= '0;
      r_cnt   <= '0;
      r_flag  <= '0;
      r_seq   <= '0;
      r_scr   <= 1'b0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_seq   <= w_seq_d;
      r_dout  <= w_dout_d;
      r_valid <= w_valid_d;
      r_sop   <= w_sop_d;
      r_eop   <= w_eop_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      if (w_snap) begin
        r_len  <= i_length_set;
        r_flag <= i_flag_set;
        r_scr  <= i_scramble;
      end
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_dout       = r_dout;
  assign o_dout_valid = r_valid;
  assign o_dout_sop   = r_sop;
  assign o_dout_eop   = r_eop;

endmodule

// File: tb/tb_source_packet_gen.sv
// Randomized self-checking bench for source_packet_gen against a packet-level model.
module tb_source_packet_gen;

  localparam int unsigned LenW = 24;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_start;
  logic [31:0]     i_packet_head;
  logic [15:0]     i_flag_set;
  logic [LenW-1:0] i_length_set;
  logic            i_scramble;
  logic            i_dout_ready;
  logic            o_busy, o_done, o_dout_valid, o_dout_sop, o_dout_eop;
  logic [31:0]     o_dout;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [33:0] q_word[$];    // {sop, eop, data} as accepted by the sink
  logic [33:0] exp_word[$];
  int          stall_errs, busy_errs, done_early, done_lag;
  logic        done_busy;
  logic [15:0] tb_seq;

  source_packet_gen #(
    .LFSR_SEED(16'hACE1),
    .LEN_W    (LenW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_packet_head(i_packet_head),
    .i_flag_set   (i_flag_set),
    .i_length_set (i_length_set),
    .i_scramble   (i_scramble),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_dout       (o_dout),
    .o_dout_valid (o_dout_valid),
    .i_dout_ready (i_dout_ready),
    .o_dout_sop   (o_dout_sop),
    .o_dout_eop   (o_dout_eop)
  );

  always #5 clk = ~clk;

  // Packet as the sink should see it: head, length, flag|seq, then payload word k
  // XORed with the scrambler state that polynomial reaches after k steps from the seed.
  function automatic void build_exp(input logic [31:0] head, input int unsigned len,
                                    input logic [15:0] flag, input bit scr,
                                    input logic [15:0] seq);
    logic [15:0] l;
    l = 16'hACE1;
    exp_word.delete();
    exp_word.push_back({1'b1, 1'b0, head});
    exp_word.push_back({2'b00, len});
    exp_word.push_back({1'b0, (len == 0), flag, seq});
    for (int unsigned k = 0; k < len; k++) begin
      exp_word.push_back({1'b0, (k == len - 1), k ^ (scr ? {l, l} : 32'h0)});
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    i_start = 1'b0;
    i_dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tb_seq = 16'h0;
    @(negedge clk);
  endtask

  task automatic start_pkt(input logic [31:0] head, input int unsigned len,
                           input logic [15:0] flag, input bit scr);
    @(negedge clk);
    i_packet_head = head;
    i_length_set = LenW'(len);
    i_flag_set = flag;
    i_scramble = scr;
    i_start = 1'b1;
    build_exp(head, len, flag, scr, tb_seq);
    tb_seq = tb_seq + 16'd1;
  endtask

  // Sink side: records accepted words, watches stall stability, busy and done timing.
  task automatic collect(input bit rand_ready, input bit poke, input int budget,
                         output bit timed_out);
    bit          prev_stall;
    logic [33:0] prev;
    bit          seen_eop;
    int          lag;
    prev_stall = 0; prev = '0; seen_eop = 0; lag = 0; timed_out = 1;
    q_word.delete();
    stall_errs = 0; busy_errs = 0; done_early = 0; done_lag = -1; done_busy = 1'bx;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (prev_stall && (o_dout_valid !== 1'b1 ||
                         {o_dout_sop, o_dout_eop, o_dout} !== prev)) stall_errs++;
      if (seen_eop) begin
        lag++;
        if (o_done === 1'b1) begin
          done_lag = lag;
          done_busy = o_busy;
          timed_out = 0;
          break;
        end
        if (lag > 4) break;
      end else begin
        if (o_done === 1'b1) done_early++;
        if (o_busy !== 1'b1) busy_errs++;
      end
      i_dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) begin
        i_start = 1'($urandom_range(0, 1));
        i_packet_head = $urandom;
        i_flag_set = 16'($urandom);
        i_length_set = LenW'($urandom_range(0, 3));
        i_scramble = 1'($urandom_range(0, 1));
      end else begin
        i_start = 1'b0;
      end
      if (o_dout_valid === 1'b1 && i_dout_ready) begin
        q_word.push_back({o_dout_sop, o_dout_eop, o_dout});
        if (o_dout_eop === 1'b1) seen_eop = 1;
      end
      prev_stall = (o_dout_valid === 1'b1) && !i_dout_ready;
      prev = {o_dout_sop, o_dout_eop, o_dout};
    end
    i_start = 1'b0;
    i_dout_ready = 1'b1;
  endtask

  task automatic test_reset();
    int valid_seen;
    rst_n = 1'b0;
    i_start = 1'b0;
    i_packet_head = '0;
    i_flag_set = '0;
    i_length_set = '0;
    i_scramble = 1'b0;
    i_dout_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({o_busy, o_done, o_dout_valid, o_dout_sop, o_dout_eop, o_dout} !== 37'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy/done/valid/sop/eop/dout=%b%b%b%b%b_%08h, required all 0",
               o_busy, o_done, o_dout_valid, o_dout_sop, o_dout_eop, o_dout);
    end
    rst_n = 1'b1;
    tb_seq = 16'h0;
    valid_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (o_dout_valid !== 1'b0 || o_busy !== 1'b0) valid_seen++;
    end
    n_checks++;
    if (valid_seen != 0) begin
      n_fail++;
      $display("FAIL idle_quiet: valid/busy high on %0d cycles, required 0", valid_seen);
    end
  endtask

  task automatic test_basic();
    bit to;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      if (p == 0) start_pkt(32'hA5A5_0001, 2, 16'h00F0, 1'b0);
      else start_pkt($urandom, $urandom_range(0, 12), 16'($urandom), 1'($urandom_range(0, 1)));
      collect(1'b0, 1'b0, 60, to);
      n_checks++;
      if (to !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_timeout pkt%0d: done seen=%0b, required 1", p, !to);
      end
      n_checks++;
      if (q_word.size() != exp_word.size()) begin
        n_fail++;
        $display("FAIL basic_count pkt%0d: got %0d words, required %0d", p, q_word.size(),
                 exp_word.size());
      end
      for (int i = 0; i < exp_word.size() && i < q_word.size(); i++) begin
        n_checks++;
        if (q_word[i] !== exp_word[i]) begin
          n_fail++;
          $display("FAIL basic_word pkt%0d w%0d: got sop/eop/data %09h, required %09h", p, i,
                   q_word[i], exp_word[i]);
        end
      end
      n_checks++;
      if (done_lag != 1 || done_busy !== 1'b0 || busy_errs != 0 || done_early != 0) begin
        n_fail++;
        $display("FAIL basic_done pkt%0d: got lag=%0d busy_at_done=%b busy_gaps=%0d early=%0d, required 1/0/0/0",
                 p, done_lag, done_busy, busy_errs, done_early);
      end
    end
  endtask

  task automatic test_zero_len();
    bit to;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      start_pkt($urandom, 0, 16'($urandom), 1'($urandom_range(0, 1)));
      collect(1'b0, 1'b0, 30, to);
      n_checks++;
      if (to !== 1'b0 || q_word.size() != 3) begin
        n_fail++;
        $display("FAIL zero_len_count pkt%0d: got %0d words (timeout=%0b), required 3", p,
                 q_word.size(), to);
      end
      for (int i = 0; i < exp_word.size() && i < q_word.size(); i++) begin
        n_checks++;
        if (q_word[i] !== exp_word[i]) begin
          n_fail++;
          $display("FAIL zero_len_word pkt%0d w%0d: got %09h, required %09h", p, i, q_word[i],
                   exp_word[i]);
        end
      end
      n_checks++;
      if (q_word.size() < 3 || q_word[2][15:0] !== 16'(p)) begin
        n_fail++;
        $display("FAIL zero_len_seq pkt%0d: got flag word %09h, required seq field %04h", p,
                 (q_word.size() < 3) ? 34'h0 : q_word[2], 16'(p));
      end
    end
  endtask

  task automatic test_scramble();
    bit to;
    do_reset();
    start_pkt(32'h1234_5678, 2, 16'hBEEF, 1'b1);
    collect(1'b0, 1'b0, 30, to);
    n_checks++;
    if (to !== 1'b0 || q_word.size() != 5) begin
      n_fail++;
      $display("FAIL scramble_count: got %0d words (timeout=%0b), required 5", q_word.size(), to);
    end
    for (int i = 0; i < exp_word.size() && i < q_word.size(); i++) begin
      n_checks++;
      if (q_word[i] !== exp_word[i]) begin
        n_fail++;
        $display("FAIL scramble_word w%0d: got %09h, required %09h", i, q_word[i], exp_word[i]);
      end
    end
    n_checks++;
    if (q_word.size() < 5 || q_word[3][31:0] !== 32'hACE1_ACE1 ||
        q_word[4][31:0] !== 32'h59C3_59C2) begin
      n_fail++;
      $display("FAIL scramble_known: got payload %08h %08h, required ACE1ACE1 59C359C2",
               (q_word.size() < 5) ? 32'h0 : q_word[3][31:0],
               (q_word.size() < 5) ? 32'h0 : q_word[4][31:0]);
    end
  endtask

  task automatic test_backpressure();
    bit          to;
    int unsigned len;
    do_reset();
    for (int p = 0; p < 5; p++) begin
      len = $urandom_range(0, 10);
      start_pkt($urandom, len, 16'($urandom), 1'($urandom_range(0, 1)));
      collect(1'b1, 1'b1, 4 * (int'(len) + 3) + 60, to);
      n_checks++;
      if (to !== 1'b0 || q_word.size() != exp_word.size()) begin
        n_fail++;
        $display("FAIL bp_count pkt%0d: got %0d words (timeout=%0b), required %0d", p,
                 q_word.size(), to, exp_word.size());
      end
      for (int i = 0; i < exp_word.size() && i < q_word.size(); i++) begin
        n_checks++;
        if (q_word[i] !== exp_word[i]) begin
          n_fail++;
          $display("FAIL bp_word pkt%0d w%0d: got %09h, required %09h", p, i, q_word[i],
                   exp_word[i]);
        end
      end
      n_checks++;
      if (stall_errs != 0 || busy_errs != 0 || done_early != 0 || done_lag != 1) begin
        n_fail++;
        $display("FAIL bp_stable pkt%0d: got stall_changes=%0d busy_gaps=%0d early_done=%0d lag=%0d, required 0/0/0/1",
                 p, stall_errs, busy_errs, done_early, done_lag);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    do_reset();
    start_pkt($urandom, 8, 16'($urandom), 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      i_start = 1'b0;
    end
    n_checks++;
    if ({o_dout_valid, o_dout_eop, o_dout} !== {1'b1, 1'b0, 32'd3}) begin
      n_fail++;
      $display("FAIL mid_word3: got valid/eop/data %b%b_%08h, required 10_00000003",
               o_dout_valid, o_dout_eop, o_dout);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_busy, o_done, o_dout_valid, o_dout_sop, o_dout_eop, o_dout} !== 37'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got busy/done/valid/sop/eop/dout=%b%b%b%b%b_%08h, required all 0",
               o_busy, o_done, o_dout_valid, o_dout_sop, o_dout_eop, o_dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tb_seq = 16'h0;
    start_pkt($urandom, 2, 16'($urandom), 1'b1);
    collect(1'b0, 1'b0, 30, to);
    n_checks++;
    if (to !== 1'b0 || q_word.size() != exp_word.size()) begin
      n_fail++;
      $display("FAIL mid_after_count: got %0d words (timeout=%0b), required %0d", q_word.size(),
               to, exp_word.size());
    end
    for (int i = 0; i < exp_word.size() && i < q_word.size(); i++) begin
      n_checks++;
      if (q_word[i] !== exp_word[i]) begin
        n_fail++;
        $display("FAIL mid_after_word w%0d: got %09h, required %09h", i, q_word[i], exp_word[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_scramble();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
